// File: rtl/slip_arb_pkg.sv
// slip_arb_pkg: shared state type, requester limit and reference round-robin pick
package slip_arb_pkg;
   localparam int ARB_MAXREQ = 8;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} slip_arb_state_t;
   // first set request after ptr, searching ptr+1 .. ptr+n with wrap; returns ptr when none set
   function automatic logic [2:0] rr_pick(input logic [ARB_MAXREQ-1:0] req, input logic [2:0] ptr, input int n);
      rr_pick = ptr;
      for (int k = n; k >= 1; k--)
         if (req[(int'(ptr) + k) % n]) rr_pick = 3'((int'(ptr) + k) % n);
   endfunction
endpackage

// File: rtl/slip_arb_rr_pick.sv
// slip_arb_rr_pick: rotate requests past the pointer, priority-encode, unrotate to a winner index
module slip_arb_rr_pick
   import slip_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [W-1:0]    ptr,
   output logic [W-1:0]    idx,
   output logic            valid
);
   localparam logic [W:0] N = (W+1)'(NREQ);
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0] rot;
   logic [W-1:0] off;
   logic [W:0] sum;
   always_comb begin
      dbl = {req, req};
      rot = NREQ'(dbl >> ({1'b0, ptr} + 1'b1));
      off = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (rot[i]) off = W'(i);
      sum = {1'b0, ptr} + 1'b1 + {1'b0, off};
      idx = (sum >= N) ? W'(sum - N) : W'(sum);
      valid = |req;
   end
endmodule

// File: rtl/slip_bus_arbiter.sv
// slip_bus_arbiter: round-robin owner of the MUX2 datapath, registered one-hot SEL with dead gap.
// Define SLIP_ARB_WATCHDOG_EN to force release after MAXHOLD grant cycles when others wait.
module slip_bus_arbiter
   import slip_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int GAP_CYCLES = 1,
   parameter int MAXHOLD = 64
) (
   input  logic                     MasterClock,
   input  logic                     RESETL,
   input  logic [NREQ-1:0]          REQ,
   output logic [NREQ-1:0]          SEL,
   output logic [NREQ-1:0]          GNT,
   output logic [$clog2(NREQ)-1:0]  OWNER,
   output logic                     BUSY,
   output logic                     TIMEOUT
);
   localparam int W = $clog2(NREQ);
   slip_arb_state_t state;
   logic [1:0] gap_cnt;
   logic [W-1:0] win;
   logic win_ok, wd_fire, drop;
   generate
      if (NREQ < 2 || NREQ > ARB_MAXREQ || GAP_CYCLES < 0 || GAP_CYCLES > 3 || MAXHOLD < 2) begin : g_bad
         $error("slip_bus_arbiter: parameter out of range");
      end
   endgenerate
   slip_arb_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (REQ),
      .ptr   (OWNER),
      .idx   (win),
      .valid (win_ok)
   );
`ifdef SLIP_ARB_WATCHDOG_EN
   localparam int HW = $clog2(MAXHOLD);
   logic [HW-1:0] hold;
   // hold is zero on the first GRANT cycle and saturates at MAXHOLD-1
   always_ff @(posedge MasterClock)
      if (!RESETL || state != GRANT) hold <= '0;
      else if (hold != HW'(MAXHOLD-1)) hold <= hold + 1'b1;
   assign wd_fire = (state == GRANT) && (hold == HW'(MAXHOLD-1)) && |(REQ & ~SEL);
`else
   assign wd_fire = 1'b0;
`endif
   assign drop = !REQ[OWNER] || wd_fire;
   assign GNT = SEL;
   always_ff @(posedge MasterClock)
      if (!RESETL) begin
         state   <= IDLE;
         SEL     <= '0;
         OWNER   <= W'(NREQ-1);
         BUSY    <= 1'b0;
         TIMEOUT <= 1'b0;
         gap_cnt <= '0;
      end else begin
         TIMEOUT <= 1'b0;
         case (state)
            IDLE:
               if (win_ok) begin
                  SEL   <= NREQ'(1) << win;
                  OWNER <= win;
                  BUSY  <= 1'b1;
                  state <= GRANT;
               end
            GRANT:
               if (drop) begin
                  SEL     <= '0;
                  BUSY    <= 1'b0;
                  TIMEOUT <= wd_fire;
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
               end
            GAP:
               if (gap_cnt == 2'(GAP_CYCLES-1)) state <= IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_slip_bus_arbiter.sv
// tb_slip_bus_arbiter: directed + random REQ stimulus against a transaction-level arbiter model
module tb_slip_bus_arbiter;
   localparam int NREQ = 4, GAP = 1, MAXHOLD = 8;
   logic clk = 1'b0, rstn = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] sel, gnt, prev_sel;
   logic [1:0] owner;
   logic busy, tmo;
   int passed = 0, total = 0;
   int m_sel, m_owner, m_held, m_cool, m_to, m_holding, timeouts, n;

   always #5 clk = ~clk;

   slip_bus_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .MAXHOLD(MAXHOLD)) dut (
      .MasterClock (clk),
      .RESETL      (rstn),
      .REQ         (req),
      .SEL         (sel),
      .GNT         (gnt),
      .OWNER       (owner),
      .BUSY        (busy),
      .TIMEOUT     (tmo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // one clock edge of the arbiter as the rules describe it: owner holds until it drops,
   // then GAP idle edges, then the first requester after the last owner wins
   task automatic model_step();
      bit others, wd;
      m_to = 0;
      if (!rstn) begin
         m_sel = 0; m_owner = NREQ-1; m_holding = 0; m_cool = 0; m_held = 0;
      end else if (m_holding != 0) begin
         others = (req & ~(4'(1) << m_owner)) != 0;
         wd = 0;
`ifdef SLIP_ARB_WATCHDOG_EN
         wd = (m_held >= MAXHOLD-1) && others;
`endif
         if (!req[m_owner] || wd) begin
            m_holding = 0; m_sel = 0; m_cool = GAP; m_to = int'(wd); timeouts += int'(wd);
         end else m_held++;
      end else if (m_cool > 0) m_cool--;
      else if (req != 0) begin
         for (int k = 1; k <= NREQ; k++)
            if (req[(m_owner + k) % NREQ]) begin
               m_owner = (m_owner + k) % NREQ;
               m_sel = 1 << m_owner; m_holding = 1; m_held = 0;
               break;
            end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("sel", sel, m_sel);
      check("gnt", gnt, m_sel);
      check("owner", owner, m_owner);
      check("busy", busy, m_holding);
      check("timeout", tmo, m_to);
      check("onehot0", $onehot0(sel), 1);
      if (prev_sel != 0 && sel != 0) check("no_direct_handover", sel, prev_sel);
      prev_sel = sel;
   endtask

   initial begin
      prev_sel = '0; timeouts = 0;
      m_sel = 0; m_owner = NREQ-1; m_holding = 0; m_cool = 0; m_held = 0; m_to = 0;
      // reset with all requesting, then first grant goes to requester 0
      rstn = 1'b0; req = 4'hf;
      cycle(); cycle();
      check("t1_rst_sel", sel, 0);
      check("t1_rst_busy", busy, 0);
      rstn = 1'b1;
      cycle();
      check("t1_first_gnt", gnt, 4'b0001);
      // round robin with each owner dropping briefly
      for (int o = 0; o < 5; o++) begin
         n = 0;
         while (m_holding == 0 && n < 10) begin cycle(); n++; end
         check("rr_busy", busy, 1);
         check("rr_owner", owner, o % 4);
         repeat (2) cycle();
         req[o % 4] = 1'b0;
         cycle();
         req = 4'hf;
      end
      req = '0;
      repeat (4) cycle();
      // wrap from OWNER=3
      rstn = 1'b0; cycle(); rstn = 1'b1;
      check("t3_owner_rst", owner, 3);
      req = 4'b0101;
      cycle();
      check("t3_wrap", gnt, 4'b0001);
      req = 4'b0100;
      cycle();
      check("t3_release", sel, 0);
      repeat (2) cycle();
      check("t3_next", gnt, 4'b0100);
      // simultaneous drop and new request
      req = 4'b0010;
      cycle(); check("t4_gap0", sel, 0);
      cycle(); check("t4_gap1", sel, 0);
      cycle(); check("t4_new", gnt, 4'b0010);
      // requester 1 holds while 2 waits
      cycle();
      req = 4'b0110;
`ifdef SLIP_ARB_WATCHDOG_EN
      n = 0;
      while (timeouts == 0 && n < 20) begin cycle(); n++; end
      check("t5_timeout", tmo, 1);
      check("t5_sel_low", sel, 0);
      repeat (2) cycle();
      check("t5_next", gnt, 4'b0100);
`else
      repeat (20) cycle();
      check("t5_hold", gnt, 4'b0010);
      check("t5_no_timeout", tmo, 0);
`endif
      // reset in the middle of a grant to requester 1
      req = 4'b0010;
      n = 0;
      while (!(m_holding != 0 && m_owner == 1) && n < 12) begin cycle(); n++; end
      check("t6_gnt", gnt, 4'b0010);
      rstn = 1'b0;
      cycle();
      check("t6_sel", sel, 0);
      check("t6_owner", owner, 3);
      rstn = 1'b1; req = '0;
      // random traffic with occasional resets
      for (int c = 0; c < 800; c++) begin
         rstn = ($urandom_range(99) != 0);
         for (int b = 0; b < NREQ; b++)
            if ($urandom_range(7) == 0) req[b] = ~req[b];
         cycle();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
